// File: rtl/wb_sram_bridge_if.sv
// Wishbone B4 bus bundle used between the interconnect and the SRAM bridge.
interface wb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   adr;
   logic [2:0]      cti;
   logic [1:0]      bte;
   logic [DW-1:0]   dat_w;
   logic [DW-1:0]   dat_r;
   logic [DW/8-1:0] sel;
   logic            cyc;
   logic            stb;
   logic            we;
   logic            ack;
   logic            err;

   modport slave (
      input  adr, cti, bte, dat_w, sel, cyc, stb, we,
      output dat_r, ack, err
   );

   modport master (
      output adr, cti, bte, dat_w, sel, cyc, stb, we,
      input  dat_r, ack, err
   );
endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone B4 slave bridging classic and burst cycles onto a
// single-port synchronous SRAM with one-cycle read latency.
module wb_sram_bridge #(
   parameter int                       WB_ADDR_WIDTH  = 32,
   parameter int                       WB_DATA_WIDTH  = 32,
   parameter int                       MEM_ADDR_WIDTH = 10,
   parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE      = '0
) (
   input  logic                        clk,
   input  logic                        rstn,
   wb_if.slave                         s,
   output logic                        sram_cs,
   output logic [WB_DATA_WIDTH/8-1:0]  sram_we,
   output logic [MEM_ADDR_WIDTH-1:0]   sram_addr,
   output logic [WB_DATA_WIDTH-1:0]    sram_wdata,
   input  logic [WB_DATA_WIDTH-1:0]    sram_rdata
);

   localparam int NB = WB_DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int MA = MEM_ADDR_WIDTH;
   localparam logic [WB_ADDR_WIDTH:0] WIN =
      (WB_ADDR_WIDTH+1)'(NB) << MA;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_ADDR,
      RD_DATA,
      ERR_ACK
   } state_t;

   state_t                   state;
   logic [MA-1:0]            cnt;
   logic [MA-1:0]            idx;
   logic [WB_ADDR_WIDTH-1:0] off;
   logic                     in_range;
   logic                     burst;
   logic                     req;

   // BTE wrap keeps the upper address bits and counts only the low ones
   function automatic logic [MA-1:0] nxt(
      input logic [MA-1:0] a,
      input logic [1:0]    bte
   );
      logic [MA-1:0] m;
      m = '1;
      case (bte)
         2'b01:   m = MA'(3);
         2'b10:   m = MA'(7);
         2'b11:   m = MA'(15);
         default: m = '1;
      endcase
      return (a & ~m) | ((a + 1'b1) & m);
   endfunction

   assign off      = s.adr - ADDR_BASE;
   assign in_range = (s.adr >= ADDR_BASE) && ({1'b0, off} < WIN);
   assign idx      = off[MA+LB-1:LB];
   assign burst    = (s.cti == 3'b010);
   assign req      = s.cyc & s.stb;

   assign s.ack   = req & ((state == WRITE) | (state == RD_DATA));
   assign s.err   = s.cyc & (state == ERR_ACK);
   assign s.dat_r = (req && state == RD_DATA) ? sram_rdata : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         sram_cs    <= 1'b0;
         sram_we    <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_cs <= 1'b0;
         sram_we <= '0;
         if (!s.cyc) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (s.stb) begin
                     cnt <= idx;
                     if (!in_range) begin
                        state <= ERR_ACK;
                     end else if (s.we) begin
                        state <= WRITE;
                     end else begin
                        state     <= RD_ADDR;
                        sram_cs   <= 1'b1;
                        sram_addr <= idx;
                     end
                  end
               end
               WRITE: begin
                  if (s.stb) begin
                     sram_cs    <= 1'b1;
                     sram_we    <= s.sel;
                     sram_addr  <= cnt;
                     sram_wdata <= s.dat_w;
                     cnt        <= nxt(cnt, s.bte);
                     if (!burst) state <= IDLE;
                  end
               end
               RD_ADDR: begin
                  state <= RD_DATA;
                  if (burst) begin
                     sram_cs   <= 1'b1;
                     sram_addr <= nxt(cnt, s.bte);
                  end
               end
               RD_DATA: begin
                  if (s.stb) begin
                     if (burst) begin
                        sram_cs   <= 1'b1;
                        sram_addr <= nxt(sram_addr, s.bte);
                        cnt       <= nxt(cnt, s.bte);
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     // refetch the unacked beat; its data is lost
                     sram_cs   <= 1'b1;
                     sram_addr <= cnt;
                     state     <= RD_ADDR;
                  end
               end
               ERR_ACK: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: SRAM model, reference memory and
// per-scenario tasks with randomized data and addresses.
module tb_wb_sram_bridge;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          WORDS = 1024;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        sram_cs;
   logic [3:0]  sram_we;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = '0;

   int total = 0;
   int bad = 0;
   int cyc_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   wb_if #(.AW(32), .DW(32)) bus();

   wb_sram_bridge #(
      .WB_ADDR_WIDTH(32),
      .WB_DATA_WIDTH(32),
      .MEM_ADDR_WIDTH(10),
      .ADDR_BASE(BASE)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .s(bus),
      .sram_cs(sram_cs),
      .sram_we(sram_we),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // initial SRAM contents; word 2 starts cleared
   function automatic logic [31:0] init_pat(input int a);
      if (a == 2) return 32'h0;
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   logic [31:0] sram_mem [WORDS];
   bit          sram_wr [WORDS];

   always @(posedge clk) begin
      if (sram_cs) begin
         logic [31:0] cur;
         cur = sram_wr[sram_addr] ? sram_mem[sram_addr] : init_pat(int'(sram_addr));
         if (sram_we == 4'b0000) begin
            sram_rdata <= cur;
         end else begin
            for (int b = 0; b < 4; b++)
               if (sram_we[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
            sram_mem[sram_addr] <= cur;
            sram_wr[sram_addr]  <= 1'b1;
         end
      end
   end

   typedef struct {
      int          cyc;
      logic [9:0]  addr;
      logic [3:0]  we;
      logic [31:0] wd;
   } acc_t;

   acc_t log_q[$];

   always @(negedge clk)
      if (sram_cs === 1'b1)
         log_q.push_back('{cyc_n, sram_addr, sram_we, sram_wdata});

   logic [31:0] ref_mem [WORDS];

   function automatic void ref_wr(input int i, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
   endfunction

   // k-th word of a burst: linear over the window or wrapping in a 4/8/16 block
   function automatic int beat_idx(input int start, input int k, input int bte);
      int w;
      w = (bte == 0) ? WORDS : (4 << (bte - 1));
      return (start / w) * w + ((start % w) + k) % w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      bus.cti = 3'b000;
      bus.bte = 2'b00;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.cyc = 1'b1;
      bus.stb = 1'b1;
      bus.we  = 1'b0;
      bus.adr = BASE + 32'd8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
         total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
         total++; if (sram_cs !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", sram_cs); end
      end
      total++; if (bus.dat_r !== 32'h0) begin bad++; $display("FAIL reset_dat_r got=%h exp=0", bus.dat_r); end
      total++; if (sram_we !== 4'h0) begin bad++; $display("FAIL reset_we got=%h exp=0", sram_we); end
      total++; if (sram_addr !== 10'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
      total++; if (sram_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", sram_wdata); end
      bus_idle();
      @(negedge clk);
      rstn = 1'b1;
      step();
      step();
   endtask

   task automatic test_write_single();
      bus.cyc   = 1'b1;
      bus.stb   = 1'b1;
      bus.we    = 1'b1;
      bus.adr   = BASE + 32'd8;
      bus.dat_w = 32'hDEAD_BEEF;
      bus.sel   = 4'b0011;
      bus.cti   = 3'b000;
      @(negedge clk);
      total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL ws_ack_n got=%b exp=0", bus.ack); end
      step();
      @(negedge clk);
      total++; if (bus.ack !== 1'b1) begin bad++; $display("FAIL ws_ack_n1 got=%b exp=1", bus.ack); end
      step();
      bus_idle();
      @(negedge clk);
      total++; if (sram_cs !== 1'b1) begin bad++; $display("FAIL ws_cs got=%b exp=1", sram_cs); end
      total++; if (sram_we !== 4'b0011) begin bad++; $display("FAIL ws_we got=%b exp=0011", sram_we); end
      total++; if (sram_addr !== 10'd2) begin bad++; $display("FAIL ws_addr got=%0d exp=2", sram_addr); end
      total++; if (sram_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ws_wdata got=%h exp=deadbeef", sram_wdata); end
      ref_wr(2, 32'hDEAD_BEEF, 4'b0011);
      step();
   endtask

   task automatic test_read_single();
      bus.cyc = 1'b1;
      bus.stb = 1'b1;
      bus.we  = 1'b0;
      bus.adr = BASE + 32'd8;
      bus.cti = 3'b000;
      @(negedge clk);
      total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL rs_ack_n got=%b exp=0", bus.ack); end
      step();
      @(negedge clk);
      total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL rs_ack_n1 got=%b exp=0", bus.ack); end
      total++; if (sram_cs !== 1'b1 || sram_we !== 4'h0 || sram_addr !== 10'd2) begin
         bad++; $display("FAIL rs_issue got=cs%b we%h a%0d exp=cs1 we0 a2", sram_cs, sram_we, sram_addr);
      end
      step();
      @(negedge clk);
      total++; if (bus.ack !== 1'b1) begin bad++; $display("FAIL rs_ack_n2 got=%b exp=1", bus.ack); end
      total++; if (bus.dat_r !== ref_mem[2]) begin bad++; $display("FAIL rs_data got=%h exp=%h", bus.dat_r, ref_mem[2]); end
      step();
      bus_idle();
      @(negedge clk);
      total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL rs_single got=%b exp=0", bus.ack); end
      step();
   endtask

   task automatic rd_burst(input int start, input int len, input int bte,
                           input int gap_beat, input int gap_len,
                           input int drop_after, input string name);
      int beat;
      int gl;
      int n;
      int e;
      beat = 0;
      gl = gap_len;
      n = cyc_n;
      bus.cyc = 1'b1;
      bus.we  = 1'b0;
      bus.bte = 2'(bte);
      for (int c = 0; c < len + gap_len + 8 && beat < len; c++) begin
         if (beat == drop_after) break;
         e = beat_idx(start, beat, bte);
         bus.adr = BASE + 32'(4 * e);
         bus.cti = (beat == len - 1) ? 3'b111 : 3'b010;
         if (beat == gap_beat && gl > 0) begin
            bus.stb = 1'b0;
            gl--;
         end else begin
            bus.stb = 1'b1;
         end
         @(negedge clk);
         if (!bus.stb) begin
            total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL %s_gap_ack beat=%0d got=%b exp=0", name, beat, bus.ack); end
         end else if (bus.ack === 1'b1) begin
            total++; if (bus.dat_r !== ref_mem[e]) begin bad++; $display("FAIL %s_data beat=%0d got=%h exp=%h", name, beat, bus.dat_r, ref_mem[e]); end
            if (gap_len == 0) begin
               total++; if (cyc_n !== n + 2 + beat) begin bad++; $display("FAIL %s_ack_cycle beat=%0d got=%0d exp=%0d", name, beat, cyc_n - n, 2 + beat); end
            end
            beat++;
         end
         step();
      end
      bus_idle();
      total++; if (beat !== ((drop_after >= 0) ? drop_after : len)) begin
         bad++; $display("FAIL %s_beats got=%0d exp=%0d", name, beat, (drop_after >= 0) ? drop_after : len);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL %s_after_ack got=%b exp=0", name, bus.ack); end
         step();
      end
   endtask

   task automatic test_wrap_read();
      log_q.delete();
      rd_burst(6, 4, 1, -1, 0, -1, "wrap4");
      total++; if (log_q.size() !== 5) begin bad++; $display("FAIL wrap4_reads got=%0d exp=5", log_q.size()); end
      for (int k = 0; k < 5 && k < log_q.size(); k++) begin
         total++; if (log_q[k].addr !== 10'(beat_idx(6, k, 1)) || log_q[k].we !== 4'h0) begin
            bad++; $display("FAIL wrap4_addr k=%0d got=%0d we=%h exp=%0d", k, log_q[k].addr, log_q[k].we, beat_idx(6, k, 1));
         end
      end
   endtask

   task automatic test_read_gap();
      rd_burst(int'($urandom_range(0, WORDS - 1)), 5, 0, 2, 2, -1, "gap");
      rd_burst(int'($urandom_range(0, WORDS - 1)), 6, 2, 3, 1, -1, "gap8");
   endtask

   task automatic test_write_window_end();
      logic [31:0] d [3];
      logic [3:0]  s [3];
      int n;
      int beat;
      for (int k = 0; k < 3; k++) begin
         d[k] = $urandom;
         s[k] = 4'($urandom_range(1, 15));
      end
      log_q.delete();
      n = cyc_n;
      beat = 0;
      bus.cyc = 1'b1;
      bus.we  = 1'b1;
      bus.bte = 2'b00;
      for (int c = 0; c < 9 && beat < 3; c++) begin
         bus.stb   = 1'b1;
         bus.adr   = BASE + 32'(4 * ((WORDS - 1 + beat) % WORDS));
         bus.cti   = (beat == 2) ? 3'b111 : 3'b010;
         bus.dat_w = d[beat];
         bus.sel   = s[beat];
         @(negedge clk);
         if (bus.ack === 1'b1) begin
            total++; if (cyc_n !== n + 1 + beat) begin bad++; $display("FAIL wb_ack_cycle beat=%0d got=%0d exp=%0d", beat, cyc_n - n, 1 + beat); end
            beat++;
         end
         step();
      end
      bus_idle();
      step();
      step();
      total++; if (beat !== 3) begin bad++; $display("FAIL wb_beats got=%0d exp=3", beat); end
      total++; if (log_q.size() !== 3) begin bad++; $display("FAIL wb_writes got=%0d exp=3", log_q.size()); end
      for (int k = 0; k < 3 && k < log_q.size(); k++) begin
         total++; if (log_q[k].addr !== 10'((WORDS - 1 + k) % WORDS) || log_q[k].we !== s[k]
                      || log_q[k].wd !== d[k] || log_q[k].cyc !== n + 2 + k) begin
            bad++; $display("FAIL wb_write k=%0d got=a%0d we%h d%h c%0d exp=a%0d we%h d%h c%0d", k,
                            log_q[k].addr, log_q[k].we, log_q[k].wd, log_q[k].cyc - n,
                            (WORDS - 1 + k) % WORDS, s[k], d[k], 2 + k);
         end
      end
      for (int k = 0; k < 3; k++) ref_wr((WORDS - 1 + k) % WORDS, d[k], s[k]);
      rd_burst(WORDS - 1, 3, 0, -1, 0, -1, "wb_readback");
   endtask

   task automatic test_err();
      logic [31:0] a [3];
      a[0] = BASE + 32'h1000;
      a[1] = BASE - 32'd4;
      a[2] = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 1000));
      for (int i = 0; i < 3; i++) begin
         log_q.delete();
         bus.cyc = 1'b1;
         bus.stb = 1'b1;
         bus.we  = 1'($urandom_range(0, 1));
         bus.adr = a[i];
         bus.cti = (i == 2) ? 3'b010 : 3'b000;
         @(negedge clk);
         total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_n i=%0d got=%b exp=0", i, bus.err); end
         step();
         @(negedge clk);
         total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_n1 i=%0d got=%b exp=1", i, bus.err); end
         total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL err_noack i=%0d got=%b exp=0", i, bus.ack); end
         step();
         bus_idle();
         @(negedge clk);
         total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_once i=%0d got=%b exp=0", i, bus.err); end
         step();
         total++; if (log_q.size() !== 0) begin bad++; $display("FAIL err_sram i=%0d got=%0d exp=0", i, log_q.size()); end
      end
   endtask

   task automatic test_cyc_drop();
      rd_burst(int'($urandom_range(0, WORDS - 1)), 6, 0, -1, 0, 2, "drop");
   endtask

   task automatic test_random();
      int idx;
      int got;
      int n;
      logic w;
      logic [31:0] d;
      logic [3:0] s;
      for (int i = 0; i < 24; i++) begin
         idx = int'($urandom_range(0, WORDS - 1));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         s = 4'($urandom_range(1, 15));
         bus.cyc   = 1'b1;
         bus.stb   = 1'b1;
         bus.we    = w;
         bus.adr   = BASE + 32'(4 * idx);
         bus.dat_w = d;
         bus.sel   = s;
         bus.cti   = 3'b000;
         n = cyc_n;
         got = -1;
         for (int c = 0; c < 5 && got < 0; c++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
               got = cyc_n - n;
               if (!w) begin
                  total++; if (bus.dat_r !== ref_mem[idx]) begin bad++; $display("FAIL rnd_data i=%0d idx=%0d got=%h exp=%h", i, idx, bus.dat_r, ref_mem[idx]); end
               end
            end
            step();
         end
         bus_idle();
         total++; if (got !== (w ? 1 : 2)) begin bad++; $display("FAIL rnd_latency i=%0d we=%b got=%0d exp=%0d", i, w, got, w ? 1 : 2); end
         if (w) ref_wr(idx, d, s);
         step();
      end
   endtask

   task automatic test_async_reset();
      bus.cyc = 1'b1;
      bus.stb = 1'b1;
      bus.we  = 1'b0;
      bus.bte = 2'b00;
      bus.cti = 3'b010;
      bus.adr = BASE + 32'h40;
      step();
      step();
      @(negedge clk);
      total++; if (bus.ack !== 1'b1 || sram_cs !== 1'b1) begin
         bad++; $display("FAIL ar_pre got=ack%b cs%b exp=ack1 cs1", bus.ack, sram_cs);
      end
      #2;
      rstn = 1'b0;
      #1;
      total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL ar_ack got=%b exp=0", bus.ack); end
      total++; if (sram_cs !== 1'b0) begin bad++; $display("FAIL ar_cs got=%b exp=0", sram_cs); end
      total++; if (bus.dat_r !== 32'h0) begin bad++; $display("FAIL ar_dat_r got=%h exp=0", bus.dat_r); end
      bus_idle();
      @(negedge clk);
      rstn = 1'b1;
      step();
      step();
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_pat(i);
      bus_idle();
      bus.adr   = '0;
      bus.dat_w = '0;
      bus.sel   = '0;
      test_reset();
      test_write_single();
      test_read_single();
      test_wrap_read();
      test_read_gap();
      test_write_window_end();
      test_err();
      test_cyc_drop();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_sram_bridge.md
# wb_sram_bridge

Wishbone B4 slave that terminates one slave port of the Wishbone interconnect and drives a single-port synchronous SRAM (one-cycle read latency, byte write enables). Supports classic single cycles and incrementing bursts (CTI=010) with linear or wrapping (BTE) address sequences, pipelining read bursts to one beat per cycle. Accesses outside the configured window complete with ERR.

## Interface
- WB_ADDR_WIDTH, 32, Wishbone byte-address width
- WB_DATA_WIDTH, 32, data width (multiple of 8); NB = WB_DATA_WIDTH/8 byte lanes
- MEM_ADDR_WIDTH, 10, SRAM word-address width; window size = NB << MEM_ADDR_WIDTH bytes
- ADDR_BASE, 'h0, byte base address of the window (NB-aligned)
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- s  wb_if.slave  -  ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE in; DAT_R, ACK, ERR out
- sram_cs  out  1  SRAM access enable
- sram_we  out  NB  byte write enables (0 = read)
- sram_addr  out  MEM_ADDR_WIDTH  word address
- sram_wdata  out  WB_DATA_WIDTH  write data
- sram_rdata  in  WB_DATA_WIDTH  read data, valid the cycle after sram_cs with sram_we=0

## Operation
- Word index idx = (ADR - ADDR_BASE) >> log2(NB); in-range iff ADR >= ADDR_BASE and (ADR - ADDR_BASE) < window size.
- States: IDLE, WRITE, RD_ADDR, RD_DATA, ERR_ACK.
- IDLE: on CYC&STB: out-of-range -> ERR_ACK; WE=1 -> WRITE; WE=0 -> RD_ADDR with sram_cs=1, sram_we=0, sram_addr=idx registered. Address counter loaded with idx.
- WRITE: ACK = CYC&STB. Each acked beat registers sram_cs=1, sram_we=SEL, sram_addr=counter, sram_wdata=DAT_W (write lands next cycle); counter advances. Exit to IDLE after a beat acked with CTI!=010.
- RD_ADDR: if CTI=010, issue speculative read of next(counter); -> RD_DATA.
- RD_DATA: if STB: ACK=1, DAT_R=sram_rdata; if CTI=010, issue read of next address; else -> IDLE (speculative data discarded). If STB low in burst: no ACK, re-issue read of the current beat address, -> RD_ADDR.
- next(): BTE=00 linear idx+1 mod 2^MEM_ADDR_WIDTH; BTE=01/10/11 increment low 2/3/4 bits only, upper bits held.
- ERR_ACK: ERR=1 for one cycle, no SRAM access, -> IDLE. Bursts to out-of-range start address error on first beat only, then IDLE; master must end cycle.
- CYC low in any state: -> IDLE next cycle, no ACK/ERR, pending SRAM write still completes.
- Cycle presenting ACK/ERR: STB not re-evaluated as new request (IDLE sees it next cycle).
- Window end during linear burst wraps to word 0 (no ERR).

## Timing
- Reset values: ACK=0, ERR=0, DAT_R=0, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0; state IDLE. Async assertion mid-cycle aborts any access immediately.
- DAT_R = sram_rdata when ACK in RD_DATA, else 0.
- Classic write: request cycle N -> ACK N+1 -> SRAM write N+2. Next request earliest N+2.
- Classic read: request N -> sram_cs N+1 -> ACK+data N+2. Next request earliest N+3.
- Read burst of L beats, STB held: ACKs N+2 .. N+L+1, one per cycle.
- Write burst of L beats: ACKs N+1 .. N+L.
- Error: request N -> ERR N+1.

## Test plan
- Reset: rstn low with CYC/STB high -> ACK/ERR/sram_cs stay 0; release, single write 0xDEADBEEF to ADDR_BASE+8, SEL=0011 -> ACK at N+1, sram_we=0011, sram_addr=2 at N+2.
- Classic read back word 2 (SRAM model holding 0x0000BEEF) -> ACK exactly at N+2, DAT_R=0x0000BEEF, single ACK.
- Read burst, CTI=010, BTE=01 (wrap4), start idx 6, 4 beats last with CTI=111 -> sram_addr 6,7,4,5 (+1 speculative), 4 consecutive ACKs, IDLE after.
- Read burst with STB low at beat 2 for 2 cycles -> no ACK during gap, beat 2 data correct, no duplicate/skipped beat.
- Write linear burst from last window word -> addresses 1023, 0, 1 (MEM_ADDR_WIDTH=10).
- Access ADDR_BASE + window size -> ERR one cycle at N+1, no ACK, sram_cs never asserted; CYC dropped mid read burst -> no further ACK, IDLE.
